control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cu_pkg.sv | 27 ++
 rtl/cu_ir.sv | 39 +++
 rtl/control_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared constants for the control sequencer: FSM state codes, opcode values
// and pc_ctrl encodings.
package cu_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WAIT_INS = 3'd2;
    localparam logic [2:0] S_DECODE   = 3'd3;
    localparam logic [2:0] S_EXEC     = 3'd4;
    localparam logic [2:0] S_WRITE    = 3'd5;

    localparam logic [3:0] OPC_NOP    = 4'b0000;
    localparam logic [3:0] OPC_ALU_LO = 4'b0001;
    localparam logic [3:0] OPC_ALU_HI = 4'b0111;
    localparam logic [3:0] OPC_JMP    = 4'b1000;
    localparam logic [3:0] OPC_BZ     = 4'b1001;
    localparam logic [3:0] OPC_HALT   = 4'b1111;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;

    function automatic logic is_alu_op(input logic [3:0] opc);
        return (opc >= OPC_ALU_LO) && (opc <= OPC_ALU_HI);
    endfunction

endpackage

// File: rtl/cu_ir.sv
// Instruction register: captures the fetched word and exposes its fields.
// Fields are taken straight from the register so they stay stable until the next capture.
module cu_ir
    import cu_pkg::*;
#(
    parameter int INS_W = 16,
    parameter int OPC_W = 4,
    parameter int RD_W  = 2,
    parameter int OFF_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [INS_W-1:0] ins,
    output logic [OPC_W-1:0] opcode,
    output logic [RD_W-1:0]  rd,
    output logic [OFF_W-1:0] offset,
    output logic             alu_sel
);

    logic [INS_W-1:0] ir_r;

    // Load the instruction word when the FSM accepts it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_r <= '0;
        end else if (capture) begin
            ir_r <= ins;
        end else begin
            ir_r <= ir_r;
        end
    end

    assign opcode  = ir_r[INS_W-1 -: OPC_W];
    assign rd      = ir_r[INS_W-OPC_W-1 -: RD_W];
    assign offset  = ir_r[OFF_W-1:0];
    assign alu_sel = ir_r[OFF_W+1];

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control FSM with fully registered outputs.
// Optional wait-state watchdog enabled by defining CU_TIMEOUT_EN.
module control_sequencer
    import cu_pkg::*;
#(
    parameter int INS_W       = 16,
    parameter int OPC_W       = 4,
    parameter int RD_W        = 2,
    parameter int OFF_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [INS_W-1:0]     ins,
    input  logic                 ins_valid,
    input  logic                 alu_done,
    input  logic                 zero,
    output logic                 fetch_req,
    output logic [OFF_W-1:0]     offset_addr,
    output logic [2**RD_W-1:0]   reg_en,
    output logic                 alu_in_sel,
    output logic [2:0]           alu_func,
    output logic [1:0]           pc_ctrl,
    output logic                 en_pc_pulse,
    output logic                 busy,
    output logic                 illegal,
    output logic                 err
);

    localparam int NREG = 2**RD_W;

    logic [2:0]       state_r, state_nxt_s;
    logic             capture_s;
    logic [OPC_W-1:0] opcode_s;
    logic [3:0]       opc_s;
    logic [RD_W-1:0]  rd_s;
    logic             ir_alu_sel_s;
    logic             fetch_nxt_s, pulse_nxt_s, illegal_nxt_s, err_nxt_s;
    logic             alu_sel_nxt_s;
    logic [NREG-1:0]  reg_en_nxt_s;
    logic [1:0]       pc_nxt_s;
    logic [2:0]       alu_func_nxt_s;
    logic             alu_in_sel_r;
    logic [2:0]       alu_func_r;

    cu_ir #(
        .INS_W (INS_W),
        .OPC_W (OPC_W),
        .RD_W  (RD_W),
        .OFF_W (OFF_W)
    ) u_ir (
        .clk     (clk),
        .rst     (rst),
        .capture (capture_s),
        .ins     (ins),
        .opcode  (opcode_s),
        .rd      (rd_s),
        .offset  (offset_addr),
        .alu_sel (ir_alu_sel_s)
    );

    assign opc_s = 4'(opcode_s);

`ifdef CU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic             wait_s;
    logic             timeout_s;
    logic [CNT_W-1:0] wait_cnt_r;

    assign wait_s    = ((state_r == S_WAIT_INS) && !ins_valid) ||
                       ((state_r == S_EXEC) && !alu_done);
    assign timeout_s = wait_s && (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1));

    // Count consecutive stalled cycles; any progress or a timeout restarts it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= '0;
        end else if (wait_s && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end
`endif

    // Next state plus next value of every output, registered together below
    always_comb begin
        state_nxt_s    = state_r;
        capture_s      = 1'b0;
        fetch_nxt_s    = 1'b0;
        pulse_nxt_s    = 1'b0;
        illegal_nxt_s  = 1'b0;
        err_nxt_s      = 1'b0;
        reg_en_nxt_s   = '0;
        pc_nxt_s       = PC_HOLD;
        alu_func_nxt_s = alu_func_r;
        alu_sel_nxt_s  = alu_in_sel_r;
        case (state_r)
            S_IDLE: begin
                if (en) begin
                    state_nxt_s = S_FETCH;
                    fetch_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                state_nxt_s = S_WAIT_INS;
            end
            S_WAIT_INS: begin
                if (ins_valid) begin
                    capture_s   = 1'b1;
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_WAIT_INS;
                end
            end
            S_DECODE: begin
                if (is_alu_op(opc_s)) begin
                    state_nxt_s    = S_EXEC;
                    alu_func_nxt_s = opc_s[2:0];
                    alu_sel_nxt_s  = ir_alu_sel_s;
                end else if (opc_s == OPC_HALT) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    // NOP, JMP, BZ and undefined opcodes all retire through WRITE
                    state_nxt_s = S_WRITE;
                    pulse_nxt_s = 1'b1;
                    if (opc_s == OPC_JMP) begin
                        pc_nxt_s = PC_LOAD;
                    end else if (opc_s == OPC_BZ) begin
                        pc_nxt_s = zero ? PC_LOAD : PC_INC;
                    end else if (opc_s == OPC_NOP) begin
                        pc_nxt_s = PC_INC;
                    end else begin
                        pc_nxt_s      = PC_INC;
                        illegal_nxt_s = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (alu_done) begin
                    state_nxt_s  = S_WRITE;
                    reg_en_nxt_s = NREG'(1) << rd_s;
                    pc_nxt_s     = PC_INC;
                    pulse_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            S_WRITE: begin
                if (en) begin
                    state_nxt_s = S_FETCH;
                    fetch_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
`ifdef CU_TIMEOUT_EN
        if (timeout_s) begin
            state_nxt_s = S_IDLE;
            err_nxt_s   = 1'b1;
        end else begin
            err_nxt_s   = 1'b0;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            fetch_req    <= 1'b0;
            reg_en       <= '0;
            pc_ctrl      <= PC_HOLD;
            en_pc_pulse  <= 1'b0;
            busy         <= 1'b0;
            illegal      <= 1'b0;
            alu_func_r   <= 3'd0;
            alu_in_sel_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            fetch_req    <= fetch_nxt_s;
            reg_en       <= reg_en_nxt_s;
            pc_ctrl      <= pc_nxt_s;
            en_pc_pulse  <= pulse_nxt_s;
            busy         <= (state_nxt_s != S_IDLE);
            illegal      <= illegal_nxt_s;
            alu_func_r   <= alu_func_nxt_s;
            alu_in_sel_r <= alu_sel_nxt_s;
        end
    end

`ifdef CU_TIMEOUT_EN
    // Registered watchdog flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= err_nxt_s;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign alu_func   = alu_func_r;
    assign alu_in_sel = alu_in_sel_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: scoreboard of expected WRITE
// results, pushed at fetch time and popped when en_pc_pulse appears.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] ins;
    logic        ins_valid;
    logic        alu_done;
    logic        zero;
    logic        fetch_req;
    logic [7:0]  offset_addr;
    logic [3:0]  reg_en;
    logic        alu_in_sel;
    logic [2:0]  alu_func;
    logic [1:0]  pc_ctrl;
    logic        en_pc_pulse;
    logic        busy;
    logic        illegal;
    logic        err;

    typedef struct {
        logic [3:0] reg_en;
        logic [1:0] pc;
        logic [7:0] off;
        int         ill;
        int         lat;
        logic       alu;
        logic [2:0] func;
        logic       sel;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   fetch_cyc = 0;
    int   ill_cnt = 0;
    bit   prev_write = 1'b0;

    control_sequencer #(
        .INS_W       (16),
        .OPC_W       (4),
        .RD_W        (2),
        .OFF_W       (8),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ins         (ins),
        .ins_valid   (ins_valid),
        .alu_done    (alu_done),
        .zero        (zero),
        .fetch_req   (fetch_req),
        .offset_addr (offset_addr),
        .reg_en      (reg_en),
        .alu_in_sel  (alu_in_sel),
        .alu_func    (alu_func),
        .pc_ctrl     (pc_ctrl),
        .en_pc_pulse (en_pc_pulse),
        .busy        (busy),
        .illegal     (illegal),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: retire scoreboard entries on every WRITE cycle
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_write = 1'b0;
        end else begin
            if (fetch_req) begin
                fetch_cyc = cyc;
                ill_cnt   = 0;
            end
            if (illegal) ill_cnt++;
            if (prev_write) begin
                check_eq("post_write_pc", {30'd0, pc_ctrl}, 32'd0);
                check_eq("post_write_reg_en", {28'd0, reg_en}, 32'd0);
            end
            if (en_pc_pulse) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("reg_en", {28'd0, reg_en}, {28'd0, mon_e.reg_en});
                    check_eq("pc_ctrl", {30'd0, pc_ctrl}, {30'd0, mon_e.pc});
                    check_eq("offset_addr", {24'd0, offset_addr}, {24'd0, mon_e.off});
                    check_eq("illegal_cycles", ill_cnt, mon_e.ill);
                    check_eq("latency", cyc - fetch_cyc + 1, mon_e.lat);
                    if (mon_e.alu) begin
                        check_eq("alu_func", {29'd0, alu_func}, {29'd0, mon_e.func});
                        check_eq("alu_in_sel", {31'd0, alu_in_sel}, {31'd0, mon_e.sel});
                    end
                end
            end else if (reg_en != 4'd0) begin
                check_eq("stray_reg_en", {28'd0, reg_en}, 32'd0);
            end
            prev_write = en_pc_pulse;
        end
    end

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (fetch_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq("fetch_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_write();
        bit ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (en_pc_pulse) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq("write_timeout", 32'd0, 32'd1);
    endtask

    // Drive one instruction; the expected retirement is derived from the word itself
    task automatic do_instr(input logic [15:0] w, input logic z, input int alu_wait, input bit drop_en);
        exp_t       e;
        bit         ok;
        logic [3:0] op;
        op      = w[15:12];
        e.off   = w[7:0];
        e.ill   = 0;
        e.alu   = 1'b0;
        e.func  = 3'd0;
        e.sel   = 1'b0;
        e.lat   = 4;
        e.reg_en = 4'd0;
        e.pc    = 2'b01;
        if (op >= 4'd1 && op <= 4'd7) begin
            e.alu    = 1'b1;
            e.func   = op[2:0];
            e.sel    = w[9];
            e.reg_en = 4'd1 << w[11:10];
            e.lat    = 5 + alu_wait;
        end else if (op == 4'd8) begin
            e.pc = 2'b10;
        end else if (op == 4'd9) begin
            e.pc = z ? 2'b10 : 2'b01;
        end else if (op >= 4'd10 && op <= 4'd14) begin
            e.ill = 1;
        end
        wait_fetch(ok);
        if (!ok) return;
        if (op != 4'hF) sb_q.push_back(e);
        @(negedge clk);
        ins = w; ins_valid = 1'b1; zero = z;
        if (drop_en) en = 1'b0;
        @(negedge clk);
        ins = 16'hFFFF;
        if (op == 4'hF) begin
            ins_valid = 1'b0;
            @(negedge clk);
            check_eq("halt_busy", {31'd0, busy}, 32'd0);
            check_eq("halt_pulse", {31'd0, en_pc_pulse}, 32'd0);
            return;
        end
        @(negedge clk);
        ins_valid = 1'b0;
        if (e.alu) begin
            repeat (alu_wait) @(negedge clk);
            alu_done = 1'b1;
            @(negedge clk);
            alu_done = 1'b0;
        end
        wait_write();
        if (drop_en) begin
            @(negedge clk);
            check_eq("drop_en_busy", {31'd0, busy}, 32'd0);
            check_eq("drop_en_fetch", {31'd0, fetch_req}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        rst = 1'b0; en = 1'b0; ins = 16'd0; ins_valid = 1'b0; alu_done = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_fetch", {31'd0, fetch_req}, 32'd0);
        check_eq("rst_outputs", {reg_en, pc_ctrl, en_pc_pulse, illegal, err, alu_func, alu_in_sel},
                 32'd0);
        check_eq("rst_offset", {24'd0, offset_addr}, 32'd0);

        rst = 1'b1; en = 1'b1;
        @(negedge clk);
        check_eq("first_fetch", {31'd0, fetch_req}, 32'd1);

        do_instr(16'h1A05, 1'b0, 1, 1'b0);
        do_instr(16'h8033, 1'b0, 0, 1'b0);
        do_instr(16'h9010, 1'b1, 0, 1'b0);
        do_instr(16'h9010, 1'b0, 0, 1'b0);
        do_instr(16'hA000, 1'b0, 0, 1'b0);
        do_instr(16'h0000, 1'b0, 0, 1'b0);
        do_instr(16'h7C81, 1'b0, 0, 1'b0);
        do_instr(16'h3200, 1'b0, 3, 1'b0);
        do_instr(16'hE0C3, 1'b0, 0, 1'b0);
        do_instr(16'hF000, 1'b0, 0, 1'b0);
        do_instr(16'h0055, 1'b0, 0, 1'b1);

        // Reset while in EXEC: everything clears at once, late alu_done does nothing
        en = 1'b1;
        @(negedge clk);
        wait_fetch(ok);
        if (ok) begin
            @(negedge clk);
            ins = 16'h1A05; ins_valid = 1'b1;
            @(negedge clk);
            ins_valid = 1'b0;
            @(negedge clk);
            #2 rst = 1'b0;
            #1;
            check_eq("abort_busy", {31'd0, busy}, 32'd0);
            check_eq("abort_offset", {24'd0, offset_addr}, 32'd0);
            check_eq("abort_outputs", {reg_en, pc_ctrl, en_pc_pulse, fetch_req, alu_func}, 32'd0);
            en = 1'b0; alu_done = 1'b1;
            @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            alu_done = 1'b0;
            check_eq("abort_no_write", {28'd0, reg_en}, 32'd0);
            check_eq("abort_idle", {31'd0, busy}, 32'd0);
        end

        // Instruction never arrives
        en = 1'b1;
        @(negedge clk);
        wait_fetch(ok);
        en = 1'b0;
        n = 0;
`ifdef CU_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (err) break;
        end
        check_eq("err_latency", n, 32'd5);
        check_eq("err_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("err_pulse_width", {31'd0, err}, 32'd0);
`else
        repeat (10) @(negedge clk);
        check_eq("no_timeout_err", {31'd0, err}, 32'd0);
        check_eq("no_timeout_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
`endif
        check_eq("sb_drained", sb_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
